// File: rtl/space_invaders_pkg.sv
// Shared definitions for the space-invaders drawing engines.
// Holds screen geometry, coordinate widths, colour constants and the
// engine state encoding that the controller also decodes.
package space_invaders_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    localparam int X_W = 9;
    localparam int Y_W = 8;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MOVE  = 3'd1,
        ST_ERASE = 3'd2,
        ST_DRAW  = 3'd3,
        ST_DONE  = 3'd4
    } sprite_state_t;

    // Counter width for a dimension of n pixels (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major scan counter over a WIDTH x HEIGHT box.
// Ports:
//   CLOCK_50 - clock
//   reset    - synchronous, active-low
//   clear    - synchronous clear to (0,0), wins over enable
//   enable   - advance one pixel (cx first, then cy), wraps after last
//   cx, cy   - current column / row inside the box
//   last     - high while (cx,cy) is the final pixel of the box
module sprite_scan_counter
    import space_invaders_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 4,
    parameter int CX_W   = cnt_w(WIDTH),
    parameter int CY_W   = cnt_w(HEIGHT)
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    output logic [CX_W-1:0] cx,
    output logic [CY_W-1:0] cy,
    output logic            last
);

    localparam logic [CX_W-1:0] CX_LAST = CX_W'(WIDTH - 1);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(HEIGHT - 1);

    always_ff @(posedge CLOCK_50) begin
        if (!reset || clear) begin
            cx <= '0;
            cy <= '0;
        end else if (enable) begin
            if (cx == CX_LAST) begin
                cx <= '0;
                cy <= (cy == CY_LAST) ? '0 : cy + CY_W'(1);
            end else begin
                cx <= cx + CX_W'(1);
            end
        end
    end

    assign last = (cx == CX_LAST) && (cy == CY_LAST);

endmodule

// File: rtl/sprite_engine.sv
// Sprite box engine: answers draw/erase requests from the frame sequencer.
// Erase sweeps the box at its current corner in ERASE_COLOUR; draw first
// steps the corner left/right (saturating at X_MIN/X_MAX) and then sweeps
// the box in COLOUR. One pixel per cycle, finish pulses after the sweep.
// Ports:
//   CLOCK_50, reset       - clock, synchronous active-low reset
//   draw_req, erase_req   - one-cycle requests, honoured only when idle
//   left, right           - movement levels, sampled in the MOVE cycle
//   busy                  - high whenever the engine is not idle
//   finish                - one-cycle pulse after the last pixel
//   x, y, colour, plot    - pixel stream to the pixel mux / VGA plot port
//   pos_x, pos_y          - current box corner
module sprite_engine
    import space_invaders_pkg::*;
#(
    parameter int         WIDTH        = 8,
    parameter int         HEIGHT       = 4,
    parameter int         X_INIT       = 156,
    parameter int         Y_INIT       = 220,
    parameter int         X_MIN        = 0,
    parameter int         X_MAX        = 312,
    parameter int         STEP         = 2,
    parameter logic [2:0] COLOUR       = WHITE,
    parameter logic [2:0] ERASE_COLOUR = BLACK
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic           draw_req,
    input  logic           erase_req,
    input  logic           left,
    input  logic           right,
    output logic           busy,
    output logic           finish,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           plot,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y
);

    localparam int CX_W = cnt_w(WIDTH);
    localparam int CY_W = cnt_w(HEIGHT);

    // Position arithmetic is one bit wider and signed so that stepping past
    // either edge shows up as a comparison instead of a wrap.
    localparam logic signed [X_W:0] STEP_S = (X_W+1)'(STEP);
    localparam logic signed [X_W:0] XMIN_S = (X_W+1)'(X_MIN);
    localparam logic signed [X_W:0] XMAX_S = (X_W+1)'(X_MAX);
    localparam logic [CX_W-1:0]     CX_LAST = CX_W'(WIDTH - 1);

    sprite_state_t state, state_nxt;

    logic            cnt_clear, cnt_en, last;
    logic [CX_W-1:0] cx, cx_nxt;
    logic [CY_W-1:0] cy, cy_nxt;

    logic [X_W-1:0]  pos_x_nxt, x_nxt;
    logic [Y_W-1:0]  y_nxt;
    logic [2:0]      colour_nxt;
    logic            plot_nxt, finish_nxt, busy_nxt;

    function automatic logic [X_W-1:0] sat_x(input logic signed [X_W:0] v);
        logic signed [X_W:0] r;
        r = v;
        if (r < XMIN_S) r = XMIN_S;
        if (r > XMAX_S) r = XMAX_S;
        return r[X_W-1:0];
    endfunction

    function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] px,
                                              input logic l, input logic r);
        logic signed [X_W:0] base;
        base = signed'({1'b0, px});
        if (l && !r)      return sat_x(base - STEP_S);
        else if (r && !l) return sat_x(base + STEP_S);
        else              return px;
    endfunction

    sprite_scan_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .CX_W   (CX_W),
        .CY_W   (CY_W)
    ) u_scan (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .cx       (cx),
        .cy       (cy),
        .last     (last)
    );

    // The counter tracks the pixel currently on the outputs; it is held at
    // zero outside a sweep so every sweep starts from the box corner.
    assign cnt_en    = (state == ST_ERASE) || (state == ST_DRAW);
    assign cnt_clear = !cnt_en;

    // State and registered outputs
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state  <= ST_IDLE;
            pos_x  <= X_W'(X_INIT);
            pos_y  <= Y_W'(Y_INIT);
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            finish <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            pos_x  <= pos_x_nxt;
            x      <= x_nxt;
            y      <= y_nxt;
            colour <= colour_nxt;
            plot   <= plot_nxt;
            finish <= finish_nxt;
            busy   <= busy_nxt;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (erase_req)     state_nxt = ST_ERASE;
                else if (draw_req) state_nxt = ST_MOVE;
            end
            ST_MOVE:  state_nxt = ST_DRAW;
            ST_ERASE,
            ST_DRAW:  if (last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output values for the next cycle. Because the outputs are registered,
    // the pixel loaded here is the one the counter will point at next, and
    // the new corner from MOVE is used directly for the first draw pixel.
    always_comb begin
        pos_x_nxt  = pos_x;
        cx_nxt     = '0;
        cy_nxt     = '0;
        x_nxt      = x;
        y_nxt      = y;
        colour_nxt = colour;
        plot_nxt   = 1'b0;

        if (state == ST_MOVE)
            pos_x_nxt = step_x(pos_x, left, right);

        if (cnt_en && !last) begin
            if (cx == CX_LAST) begin
                cy_nxt = cy + CY_W'(1);
            end else begin
                cx_nxt = cx + CX_W'(1);
                cy_nxt = cy;
            end
        end

        if ((state_nxt == ST_ERASE) || (state_nxt == ST_DRAW)) begin
            plot_nxt   = 1'b1;
            x_nxt      = pos_x_nxt + X_W'(cx_nxt);
            y_nxt      = pos_y + Y_W'(cy_nxt);
            colour_nxt = (state_nxt == ST_DRAW) ? COLOUR : ERASE_COLOUR;
        end

        finish_nxt = (state_nxt == ST_DONE);
        busy_nxt   = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_sprite_engine.sv
module tb_sprite_engine;

    localparam int W      = 8;
    localparam int H      = 4;
    localparam int N      = W * H;
    localparam int XI     = 156;
    localparam int YI     = 220;
    localparam int XMAX   = 312;
    localparam int STEP   = 2;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       draw_req = 1'b0;
    logic       erase_req = 1'b0;
    logic       left     = 1'b0;
    logic       right    = 1'b0;
    logic       busy, finish, plot;
    logic [8:0] x, pos_x;
    logic [7:0] y, pos_y;
    logic [2:0] colour;

    int n_checks = 0;
    int n_fail   = 0;
    int mpos     = XI;   // reference model: current corner x

    sprite_engine dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .draw_req  (draw_req),
        .erase_req (erase_req),
        .left      (left),
        .right     (right),
        .busy      (busy),
        .finish    (finish),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .pos_x     (pos_x),
        .pos_y     (pos_y)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       er;
        logic       dr;
        logic       l;
        logic       r;
        int         exp_pos;
        logic [2:0] exp_col;
        int         inject;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected corner after one draw step, from the movement rules.
    function automatic int model_step(input int p, input logic l, input logic r);
        int q;
        q = p;
        if (l && !r) q = p - STEP;
        if (r && !l) q = p + STEP;
        if (q < 0)    q = 0;
        if (q > XMAX) q = XMAX;
        return q;
    endfunction

    // Issue one request and follow the whole response cycle by cycle.
    // inject: pixel index (0..N) at which a stray request is raised; N means
    // during the finish cycle, anything larger means no stray request.
    task automatic do_req(input logic er, input logic dr, input logic l, input logic r,
                          input int exp_pos, input logic [2:0] exp_col, input int inject);
        logic is_draw;
        is_draw   = dr && !er;
        erase_req = er;
        draw_req  = dr;
        left      = l;
        right     = r;
        tick();
        erase_req = 1'b0;
        draw_req  = 1'b0;
        if (is_draw) begin
            check("move_cycle", {plot, busy, finish}, 3'b010);
            tick();
        end
        for (int i = 0; i < N; i++) begin
            check("pix", {plot, busy, finish, colour, y, x},
                  {1'b1, 1'b1, 1'b0, exp_col, 8'(YI + i / W), 9'(exp_pos + i % W)});
            if (i == inject) begin
                draw_req  = 1'b1;
                erase_req = i[0];
            end
            tick();
            draw_req  = 1'b0;
            erase_req = 1'b0;
        end
        check("finish_cycle", {plot, busy, finish}, 3'b011);
        if (inject == N) begin
            draw_req  = 1'b1;
            erase_req = 1'b1;
        end
        tick();
        draw_req  = 1'b0;
        erase_req = 1'b0;
        check("after_finish", {plot, busy, finish}, 3'b000);
        check("pos_x", pos_x, exp_pos);
        check("pos_y", pos_y, YI);
        tick();
        check("idle_quiet", {plot, busy, finish}, 3'b000);
        left  = 1'b0;
        right = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        mpos  = XI;
    endtask

    initial begin
        logic       er, dr, l, r;
        logic [2:0] col;
        int         exp;

        // er dr l r  expected corner, colour, stray request index
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 156, 3'd0, 99};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 158, 3'd7, 99};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 158, 3'd7, 5};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 156, 3'd7, 31};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 156, 3'd0, 99};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 156, 3'd7, 32};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 156, 3'd0, 12};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 158, 3'd7, 0};

        apply_reset();
        check("reset_outs", {plot, busy, finish, colour, y, x}, 23'd0);
        check("reset_pos_x", pos_x, XI);
        check("reset_pos_y", pos_y, YI);

        // Level inputs alone must not start anything.
        left = 1'b1;
        repeat (3) tick();
        left = 1'b0;
        check("levels_only", {plot, busy, pos_x}, {2'b00, 9'(XI)});

        for (int t = 0; t < 8; t++)
            do_req(tbl[t].er, tbl[t].dr, tbl[t].l, tbl[t].r,
                   tbl[t].exp_pos, tbl[t].exp_col, tbl[t].inject);
        mpos = 158;

        // Saturation at the left edge, then at the right edge.
        for (int k = 0; k < 80; k++) begin
            mpos = model_step(mpos, 1'b1, 1'b0);
            do_req(1'b0, 1'b1, 1'b1, 1'b0, mpos, 3'd7, 99);
        end
        check("sat_left", pos_x, 0);
        for (int k = 0; k < 200; k++) begin
            mpos = model_step(mpos, 1'b0, 1'b1);
            do_req(1'b0, 1'b1, 1'b0, 1'b1, mpos, 3'd7, 99);
        end
        check("sat_right", pos_x, XMAX);

        // Randomized traffic against the model.
        for (int k = 0; k < 60; k++) begin
            er = ($urandom_range(0, 3) == 0);
            dr = er ? 1'($urandom_range(0, 1)) : 1'b1;
            l  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            if (er) begin
                exp = mpos;
                col = 3'd0;
            end else begin
                exp = model_step(mpos, l, r);
                col = 3'd7;
            end
            mpos = exp;
            do_req(er, dr, l, r, exp, col, $urandom_range(0, N + 6));
            repeat ($urandom_range(0, 3)) begin
                left  = 1'($urandom_range(0, 1));
                right = 1'($urandom_range(0, 1));
                tick();
                check("rand_idle", {plot, busy, finish}, 3'b000);
            end
            left  = 1'b0;
            right = 1'b0;
        end

        // Reset in the middle of a draw sweep.
        apply_reset();
        draw_req = 1'b1;
        right    = 1'b1;
        tick();
        draw_req = 1'b0;
        tick();                       // first pixel now on the outputs
        repeat (10) tick();           // pixel 10 now on the outputs
        check("pix10_before_reset", {plot, x}, {1'b1, 9'(158 + 2)});
        reset = 1'b0;
        tick();
        reset = 1'b1;
        right = 1'b0;
        check("midreset_outs", {plot, busy, finish}, 3'b000);
        check("midreset_pos_x", pos_x, XI);
        repeat (N + 4) begin
            tick();
            check("midreset_quiet", {plot, finish}, 2'b00);
        end
        mpos = XI;
        do_req(1'b1, 1'b0, 1'b0, 1'b0, XI, 3'd0, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
